// File: rtl/spike_window_decoder.sv
// Counts spikes over back-to-back programmable windows and emits one saturating rate per window.
// The result appears the cycle after a window ends; if the output register is still full and not taken, the result is dropped and overrun sticks.
module spike_window_decoder #(
  parameter int CNT_W       = 8,
  parameter int WIN_W       = 10,
  parameter int COUNT_EDGES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIN_W-1:0] window_len,
  input  logic             spike,
  output logic [CNT_W-1:0] rate_data,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             overrun,
  output logic             busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt, cnt_sat;
  logic [CNT_W:0]   sum;
  logic [WIN_W-1:0] timer, timer_nxt, len_q, len_nxt, len_eff;
  logic             spike_d, inc, win_end, xfer, load;

  assign inc     = (COUNT_EDGES != 0) ? (spike & ~spike_d) : spike;
  assign sum     = {1'b0, count} + {{CNT_W{1'b0}}, inc};
  assign cnt_sat = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
  assign len_eff = (window_len == '0) ? WIN_ONE : window_len;
  assign xfer    = rate_valid & rate_ready;
  // A completed window can load only into an empty register or one being drained this edge.
  assign load    = win_end & (~rate_valid | xfer);
  assign busy    = (state == RUN);

  always_comb begin
    state_nxt = state;
    count_nxt = '0;
    timer_nxt = '0;
    len_nxt   = len_q;
    win_end   = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = RUN;
          len_nxt   = len_eff;
        end
      end
      RUN: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (timer == len_q - WIN_ONE) begin
          win_end = 1'b1;
          len_nxt = len_eff;
        end else begin
          count_nxt = cnt_sat;
          timer_nxt = timer + WIN_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      timer      <= '0;
      len_q      <= WIN_ONE;
      spike_d    <= 1'b0;
      rate_data  <= '0;
      rate_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      timer   <= timer_nxt;
      len_q   <= len_nxt;
      spike_d <= spike;
      if (load) begin
        rate_data  <= cnt_sat;
        rate_valid <= 1'b1;
      end else if (xfer) begin
        rate_valid <= 1'b0;
      end
      if (win_end && !load) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spike_window_decoder.sv
// Directed bench: level-mode and edge-mode decoders share stimulus; each scenario checks its own DUT outputs.
module tb_spike_window_decoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [9:0] window_len;
  logic       spike;
  logic       rate_ready;
  logic [7:0] rate_data_l, rate_data_e;
  logic       rate_valid_l, rate_valid_e;
  logic       overrun_l, overrun_e;
  logic       busy_l, busy_e;

  int checks   = 0;
  int failures = 0;

  spike_window_decoder #(.CNT_W(8), .WIN_W(10), .COUNT_EDGES(0)) dut_l (
    .clk(clk), .rst_n(rst_n), .en(en), .window_len(window_len), .spike(spike),
    .rate_data(rate_data_l), .rate_valid(rate_valid_l), .rate_ready(rate_ready),
    .overrun(overrun_l), .busy(busy_l)
  );

  spike_window_decoder #(.CNT_W(8), .WIN_W(10), .COUNT_EDGES(1)) dut_e (
    .clk(clk), .rst_n(rst_n), .en(en), .window_len(window_len), .spike(spike),
    .rate_data(rate_data_e), .rate_valid(rate_valid_e), .rate_ready(rate_ready),
    .overrun(overrun_e), .busy(busy_e)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; en = 1'b0; spike = 1'b0; rate_ready = 1'b0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1; spike = 1'b1; rate_ready = 1'b0; window_len = 10'd4;
    tick; tick;
    checks++; if (rate_data_l !== 8'd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", rate_data_l); end
    checks++; if (rate_valid_l !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", rate_valid_l); end
    checks++; if (overrun_l !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b exp=0", overrun_l); end
    checks++; if (busy_l !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy_l); end
    checks++; if (busy_e !== 1'b0 || rate_valid_e !== 1'b0) begin failures++; $display("FAIL reset_edge_dut busy=%0b valid=%0b exp=0,0", busy_e, rate_valid_e); end
    rst_n = 1'b1;
    tick;
    checks++; if (busy_l !== 1'b1) begin failures++; $display("FAIL reset_release_busy got=%0b exp=1", busy_l); end
  endtask

  task automatic test_level;
    logic [3:0] pat;
    pat = 4'b1011;
    do_reset;
    window_len = 10'd4; rate_ready = 1'b1; en = 1'b1; spike = 1'b0;
    tick;
    checks++; if (busy_l !== 1'b1) begin failures++; $display("FAIL level_entry_busy got=%0b exp=1", busy_l); end
    for (int w = 0; w < 3; w++) begin
      for (int c = 0; c < 4; c++) begin
        spike = pat[c];
        tick;
        checks++;
        if (rate_valid_l !== (c == 3)) begin
          failures++; $display("FAIL level_valid w=%0d c=%0d got=%0b exp=%0b", w, c, rate_valid_l, (c == 3));
        end
        if (c == 3) begin
          checks++; if (rate_data_l !== 8'd3) begin failures++; $display("FAIL level_data w=%0d got=%0d exp=3", w, rate_data_l); end
        end
      end
    end
    checks++; if (overrun_l !== 1'b0) begin failures++; $display("FAIL level_overrun got=%0b exp=0", overrun_l); end
  endtask

  task automatic test_saturation;
    do_reset;
    window_len = 10'd300; rate_ready = 1'b1; en = 1'b1; spike = 1'b1;
    tick;
    for (int i = 1; i <= 300; i++) begin
      tick;
      if (i == 299) begin
        checks++; if (rate_valid_l !== 1'b0) begin failures++; $display("FAIL sat_early_valid got=%0b exp=0", rate_valid_l); end
      end
    end
    checks++; if (rate_valid_l !== 1'b1) begin failures++; $display("FAIL sat_valid got=%0b exp=1", rate_valid_l); end
    checks++; if (rate_data_l !== 8'd255) begin failures++; $display("FAIL sat_data got=%0d exp=255", rate_data_l); end
    do_reset;
    window_len = 10'd0; rate_ready = 1'b1; en = 1'b1; spike = 1'b1;
    tick;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (rate_valid_l !== 1'b1 || rate_data_l !== 8'd1) begin
        failures++; $display("FAIL len0_stream i=%0d valid=%0b data=%0d exp=1,1", i, rate_valid_l, rate_data_l);
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    window_len = 10'd2; rate_ready = 1'b0; en = 1'b1; spike = 1'b0;
    tick;
    spike = 1'b1; tick;
    spike = 1'b1; tick;
    checks++; if (rate_valid_l !== 1'b1 || rate_data_l !== 8'd2) begin failures++; $display("FAIL bp_first valid=%0b data=%0d exp=1,2", rate_valid_l, rate_data_l); end
    spike = 1'b1; tick;
    checks++; if (rate_data_l !== 8'd2 || overrun_l !== 1'b0) begin failures++; $display("FAIL bp_hold data=%0d overrun=%0b exp=2,0", rate_data_l, overrun_l); end
    spike = 1'b0; tick;
    checks++; if (rate_data_l !== 8'd2 || rate_valid_l !== 1'b1) begin failures++; $display("FAIL bp_stable data=%0d valid=%0b exp=2,1", rate_data_l, rate_valid_l); end
    checks++; if (overrun_l !== 1'b1) begin failures++; $display("FAIL bp_overrun got=%0b exp=1", overrun_l); end
    rate_ready = 1'b1; spike = 1'b0; tick;
    checks++; if (rate_valid_l !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0b exp=0", rate_valid_l); end
    rate_ready = 1'b0; spike = 1'b1; tick;
    checks++; if (rate_valid_l !== 1'b1 || rate_data_l !== 8'd1) begin failures++; $display("FAIL bp_next valid=%0b data=%0d exp=1,1", rate_valid_l, rate_data_l); end
    checks++; if (overrun_l !== 1'b1) begin failures++; $display("FAIL bp_sticky got=%0b exp=1", overrun_l); end
  endtask

  task automatic test_abort;
    do_reset;
    window_len = 10'd2; rate_ready = 1'b0; en = 1'b1; spike = 1'b0;
    tick;
    spike = 1'b1; tick;
    en = 1'b0; tick;
    checks++; if (rate_valid_l !== 1'b0 || busy_l !== 1'b0) begin failures++; $display("FAIL abort_at_end valid=%0b busy=%0b exp=0,0", rate_valid_l, busy_l); end
    window_len = 10'd8; en = 1'b1; spike = 1'b1;
    tick;
    for (int i = 0; i < 5; i++) tick;
    en = 1'b0; tick;
    checks++; if (busy_l !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b exp=0", busy_l); end
    checks++; if (rate_valid_l !== 1'b0) begin failures++; $display("FAIL abort_valid got=%0b exp=0", rate_valid_l); end
    en = 1'b1; spike = 1'b0;
    tick;
    for (int i = 1; i <= 8; i++) begin
      tick;
      if (i == 7) begin
        checks++; if (rate_valid_l !== 1'b0) begin failures++; $display("FAIL reenable_early got=%0b exp=0", rate_valid_l); end
      end
    end
    checks++; if (rate_valid_l !== 1'b1 || rate_data_l !== 8'd0) begin failures++; $display("FAIL reenable_result valid=%0b data=%0d exp=1,0", rate_valid_l, rate_data_l); end
  endtask

  task automatic test_edge_mode;
    logic [7:0] p1, p2;
    p1 = 8'b0111_0111;
    p2 = 8'b0101_0101;
    do_reset;
    window_len = 10'd8; rate_ready = 1'b0; en = 1'b1; spike = 1'b0;
    tick;
    for (int c = 0; c < 8; c++) begin spike = p1[c]; tick; end
    checks++; if (rate_valid_e !== 1'b1 || rate_data_e !== 8'd2) begin failures++; $display("FAIL edge_w1 valid=%0b data=%0d exp=1,2", rate_valid_e, rate_data_e); end
    for (int c = 0; c < 8; c++) begin
      spike = p2[c]; rate_ready = (c == 7);
      tick;
      if (c < 7) begin
        checks++; if (rate_valid_e !== 1'b1 || rate_data_e !== 8'd2) begin failures++; $display("FAIL edge_hold c=%0d valid=%0b data=%0d exp=1,2", c, rate_valid_e, rate_data_e); end
      end
    end
    checks++; if (rate_valid_e !== 1'b1 || rate_data_e !== 8'd4) begin failures++; $display("FAIL edge_xfer_load valid=%0b data=%0d exp=1,4", rate_valid_e, rate_data_e); end
    checks++; if (overrun_e !== 1'b0) begin failures++; $display("FAIL edge_xfer_overrun got=%0b exp=0", overrun_e); end
    rate_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      spike = p1[c];
      tick;
      if (c == 0) begin
        checks++; if (rate_valid_e !== 1'b0) begin failures++; $display("FAIL edge_drain got=%0b exp=0", rate_valid_e); end
      end
    end
    checks++; if (rate_valid_e !== 1'b1 || rate_data_e !== 8'd2) begin failures++; $display("FAIL edge_w3 valid=%0b data=%0d exp=1,2", rate_valid_e, rate_data_e); end
    checks++; if (overrun_e !== 1'b0) begin failures++; $display("FAIL edge_overrun got=%0b exp=0", overrun_e); end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; spike = 1'b0; rate_ready = 1'b0; window_len = 10'd0;
    test_reset;
    test_level;
    test_saturation;
    test_backpressure;
    test_abort;
    test_edge_mode;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
